// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pkg                                                            |
// | Raster types and default timing shared by capture and output paths.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package video_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vout_state_t;

    localparam int unsigned c_H_PIXELS = 640;
    localparam int unsigned c_H_BLANK  = 160;
    localparam int unsigned c_V_LINES  = 480;
    localparam int unsigned c_V_BLANK  = 40;

    // A counter over a single value still needs one bit to exist.
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_timing_cnt                                                     |
// | Horizontal/vertical wrap counters for a raster of H_TOTAL x V_TOTAL. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module video_timing_cnt import video_pkg::*; #(
    parameter int unsigned H_TOTAL = c_H_PIXELS + c_H_BLANK,
    parameter int unsigned V_TOTAL = c_V_LINES + c_V_BLANK,
    parameter int unsigned H_W     = cnt_width(H_TOTAL),
    parameter int unsigned V_W     = cnt_width(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           last_pix,
    output logic           last_frame
);

    localparam logic [H_W-1:0] c_H_MAX = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] c_V_MAX = V_W'(V_TOTAL - 1);

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;

    // last_frame marks the final line; the final cycle is last_pix && last_frame.
    assign last_pix   = (r_h_cnt == c_H_MAX);
    assign last_frame = (r_v_cnt == c_V_MAX);
    assign h_cnt      = r_h_cnt;
    assign v_cnt      = r_v_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (en) begin
            if (last_pix) begin
                r_h_cnt <= '0;
                r_v_cnt <= last_frame ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_out                                                            |
// | Pops pixels from a FWFT FIFO and emits frame/line-valid raster video.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module video_out import video_pkg::*; #(
    parameter int unsigned H_PIXELS = c_H_PIXELS,
    parameter int unsigned H_BLANK  = c_H_BLANK,
    parameter int unsigned V_LINES  = c_V_LINES,
    parameter int unsigned V_BLANK  = c_V_BLANK
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       enable,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       r_e,
    output logic       frame_valid,
    output logic       line_valid,
    output logic [7:0] pixel_out,
    output logic       underflow
);

    localparam int unsigned c_H_TOTAL = H_PIXELS + H_BLANK;
    localparam int unsigned c_V_TOTAL = V_LINES + V_BLANK;
    localparam int unsigned c_H_W     = cnt_width(c_H_TOTAL);
    localparam int unsigned c_V_W     = cnt_width(c_V_TOTAL);

    localparam logic [0:0] c_ST_IDLE = IDLE;
    localparam logic [0:0] c_ST_RUN  = RUN;

    logic [0:0]       r_state;
    logic [c_H_W-1:0] w_h_cnt;
    logic [c_V_W-1:0] w_v_cnt;
    logic             w_last_pix;
    logic             w_last_line;
    logic             w_run;
    logic             w_fv;
    logic             w_act;
    pixel_t           w_pix_next;

    assign w_run = (r_state == c_ST_RUN);

    video_timing_cnt #(
        .H_TOTAL (c_H_TOTAL),
        .V_TOTAL (c_V_TOTAL),
        .H_W     (c_H_W),
        .V_W     (c_V_W)
    ) u_timing (
        .clk        (clk),
        .rst        (RST),
        .clr        (!w_run),
        .en         (w_run),
        .h_cnt      (w_h_cnt),
        .v_cnt      (w_v_cnt),
        .last_pix   (w_last_pix),
        .last_frame (w_last_line)
    );

    // Compare at 32 bits so an unblanked axis cannot truncate its limit.
    assign w_fv       = w_run && (32'(w_v_cnt) < V_LINES);
    assign w_act      = w_fv && (32'(w_h_cnt) < H_PIXELS);
    assign r_e        = !RST && w_act && !fifo_empty;
    assign w_pix_next = (w_act && !fifo_empty) ? fifo_data : 8'h00;

    // Frames only end at their final cycle, so enable is looked at only there.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (enable && !fifo_empty) r_state <= c_ST_RUN;
                c_ST_RUN:  if (w_last_pix && w_last_line && !enable) r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            pixel_out   <= 8'h00;
            underflow   <= 1'b0;
        end else begin
            frame_valid <= w_fv;
            line_valid  <= w_act;
            pixel_out   <= w_pix_next;
            if (w_act && fifo_empty) underflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/video_out.md
# video_out

Transmit-side counterpart of the camera capture path. It pops 8-bit pixels from a first-word-fall-through FIFO and serializes them into the same raster protocol the capture side consumes: `frame_valid`, `line_valid`, and an 8-bit pixel bus. Timing is generated locally from programmable active and blanking sizes. The block sits between the frame-buffer read FIFO and the video output pins, or a loopback into the capture path.

## Interface
- `H_PIXELS`, 640: active pixels per line
- `H_BLANK`, 160: blanking cycles after each line (line_valid low)
- `V_LINES`, 480: active lines per frame
- `V_BLANK`, 40: blanking lines after the last active line (frame_valid low)
- `clk`  in  1  sole clock; all logic is rising-edge
- `RST`  in  1  reset, synchronous, active-high
- `enable`  in  1  request to stream frames
- `fifo_data`  in  8  FIFO head word, valid whenever `fifo_empty`=0
- `fifo_empty`  in  1  FIFO empty flag
- `r_e`  out  1  FIFO pop strobe (combinational)
- `frame_valid`  out  1  high during all cycles of active lines (registered)
- `line_valid`  out  1  high during active pixels (registered)
- `pixel_out`  out  8  pixel, meaningful when `line_valid`=1 and 0x00 otherwise (registered)
- `underflow`  out  1  sticky: an active pixel found the FIFO empty

## Operation
- Counters: `h_cnt` wraps at 0..H_PIXELS+H_BLANK-1. `v_cnt` wraps at 0..V_LINES+V_BLANK-1 and increments when `h_cnt` wraps. Widths are $clog2 of the respective totals.
- `act` = RUN && h_cnt<H_PIXELS && v_cnt<V_LINES. `fv` = RUN && v_cnt<V_LINES.
- FSM states:
  - IDLE: counters held at 0, all outputs low. Leave to RUN when `enable`=1 && `fifo_empty`=0, so a frame never starts from an empty FIFO.
  - RUN: counters free-run. Sample `enable` only at the last cycle of a frame (h and v both at max). If 0, go to IDLE; if 1, stay in RUN and start the next frame immediately.
  - `enable` falling mid-frame never truncates a frame.
- `r_e` = `act` && !`fifo_empty`. A pop happens only when data is present.
- Pixel register:
  - On `act` with data present: `pixel_out` ← `fifo_data`.
  - On `act` with the FIFO empty: `pixel_out` ← 0x00, no pop, `underflow` ← 1. Raster timing never stalls.
  - Otherwise `pixel_out` ← 0x00.
- `underflow` clears only on `RST`.

## Timing
- Reset values: `frame_valid`=0, `line_valid`=0, `pixel_out`=0x00, `underflow`=0, state IDLE, counters 0. `r_e` is 0 while `RST`=1.
- `RST` mid-frame aborts at the next edge. There is no partial-line completion.
- Start latency: if the IDLE exit condition is true at edge N, RUN begins at N+1 with `r_e`=1 in that cycle. The first `frame_valid`/`line_valid`/pixel appear after edge N+2.
- Output latency from the counters is exactly 1 cycle. `frame_valid`, `line_valid` and `pixel_out` are mutually aligned.
- Per line: H_PIXELS consecutive `line_valid` cycles, then H_BLANK low cycles with `frame_valid` held high.
- Per frame: V_LINES lines with `frame_valid` high, then V_BLANK×(H_PIXELS+H_BLANK) cycles with `frame_valid` low.
- Back-to-back frames: the first active cycle of frame k+1 directly follows the last blanking cycle of frame k.
- Pop and pixel use are 1:1. Exactly H_PIXELS×V_LINES pops per frame when there is no underflow.

## Structure
- Shared package `video_pkg`: `pixel_t` (logic [7:0]), FSM enum `vout_state_t` {IDLE, RUN}, default timing constants. These are shared with the capture side so both ends agree on the raster.
- Sub-module `video_timing_cnt`: h/v wrap counters with `clr`/`en` inputs and `last_pix`/`last_frame` flags. It is reusable by a capture-side timing checker.

## Test plan
Bench parameters: H_PIXELS=4, H_BLANK=2, V_LINES=3, V_BLANK=1 (24 cycles/frame).
- Reset then `enable`=1 with FIFO preloaded 0x01..0x0C:
  - `frame_valid` rises 2 cycles after `enable` is sampled.
  - Lines carry 01-04, 05-08, 09-0C.
  - Each line has 4 `line_valid` cycles with 2-cycle gaps.
  - `frame_valid` is low for 6 cycles after the last line; `underflow`=0.
- `enable`=1 with an empty FIFO for 10 cycles: stays IDLE, all outputs 0. Writing one word starts a frame on the next edge.
- FIFO holds only 6 words:
  - Pixels 7-12 are output as 0x00 and `r_e` stays 0 for them.
  - `underflow` goes to 1 and stays 1 through later frames.
  - `line_valid`/`frame_valid` timing is unchanged.
- `enable` dropped during line 2 of a frame: the frame completes all 12 pixels, then returns to IDLE. No second frame.
- `enable` held with a continuously fed FIFO: two frames are back-to-back, 24 cycles apart, with 12 pops each.
- `RST` asserted at pixel 6: outputs are 0 at the next edge and `underflow`=0. After release with `enable`=1, a fresh frame starts from pixel 0.
